// File: rtl/divclk_tick_receiver_pkg.sv
// Shared definitions for the divided-clock tick receiver.
// Holds the receiver state encoding and edge-mode selectors.
// Also holds the saturating error-count helper used by the top.
package divclk_tick_receiver_pkg;

   // Receiver state encoding
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACQUIRE = 3'd1,
      ST_TRACK   = 3'd2,
      ST_LOCKED  = 3'd3,
      ST_LOST    = 3'd4
   } rx_state_t;

   // Edge-mode selectors for the EDGE_MODE parameter
   localparam int EDGE_RISE = 0;
   localparam int EDGE_BOTH = 1;

   // Width of the saturating error counter
   localparam int ERR_W = 8;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/divclk_tick_receiver_sync_edge_detect.sv
// Synchronises div_in into clk and flags its qualifying transitions.
// Latency: edge_o pulses 2 cycles after the cycle div_in is first sampled.
// Backpressure: none; every synchronised transition produces one pulse.
module divclk_tick_receiver_sync_edge_detect
   import divclk_tick_receiver_pkg::*;
#(
   parameter int EDGE_MODE = EDGE_BOTH
) (
   input  logic clk,
   input  logic reset,
   input  logic div_in,
   output logic edge_o
);

   logic sync1_q;
   logic sync2_q;
   logic hist_q;
   logic edge_q;
   logic rise;
   logic fall;
   logic edge_d;

   // Two-flop synchroniser, history flop and registered edge pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         sync1_q <= div_in;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
         edge_q  <= edge_d;
      end
   end

   // Qualify transitions of the synchronised signal by edge mode
   always_comb begin
      rise   = sync2_q & ~hist_q;
      fall   = ~sync2_q & hist_q;
      edge_d = (EDGE_MODE == EDGE_RISE) ? rise : (rise | fall);
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/divclk_tick_receiver.sv
// Converts a slow, possibly asynchronous divided clock into clk-domain ticks plus lock status.
// Latency: tick is 3 cycles after div_in is sampled; period/locked/lost/err_cnt update with tick.
// Backpressure: none; ticks are strobes and cannot be stalled by downstream logic.
module divclk_tick_receiver
   import divclk_tick_receiver_pkg::*;
#(
   parameter int EDGE_MODE       = EDGE_BOTH,
   parameter int EXPECTED_PERIOD = 10000,
   parameter int TOLERANCE       = 16,
   parameter int LOCK_COUNT      = 4,
   parameter int CNT_W           = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_in,
   input  logic             enable,
   output logic             tick,
   output logic [CNT_W-1:0] period,
   output logic             locked,
   output logic             lost,
   output logic [7:0]       err_cnt
);

   // Tolerance window; HI_LIM doubles as the loss-of-clock threshold
   localparam logic [CNT_W-1:0] LO_LIM = CNT_W'(EXPECTED_PERIOD - TOLERANCE);
   localparam logic [CNT_W-1:0] HI_LIM = CNT_W'(EXPECTED_PERIOD + TOLERANCE);
   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_COUNT);

   logic              edge_w;
   rx_state_t         state_q;
   rx_state_t         state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [CNT_W-1:0]  period_q;
   logic [CNT_W-1:0]  period_d;
   logic [CNT_W-1:0]  interval;
   logic [GOOD_W-1:0] good_q;
   logic [GOOD_W-1:0] good_d;
   logic [GOOD_W-1:0] good_inc;
   logic [ERR_W-1:0]  err_q;
   logic [ERR_W-1:0]  err_d;
   logic              tick_q;
   logic              tick_d;
   logic              locked_q;
   logic              locked_d;
   logic              lost_q;
   logic              lost_d;
   logic              cnt_sat;
   logic              ival_good;

   divclk_tick_receiver_sync_edge_detect #(
      .EDGE_MODE (EDGE_MODE)
   ) u_sync_edge (
      .clk    (clk),
      .reset  (reset),
      .div_in (div_in),
      .edge_o (edge_w)
   );

   // Saturating interval arithmetic and tolerance-window test
   always_comb begin
      cnt_sat   = (cnt_q == '1);
      interval  = cnt_sat ? cnt_q : cnt_q + 1'b1;
      ival_good = (interval >= LO_LIM) && (interval <= HI_LIM);
      good_inc  = good_q + 1'b1;
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         good_q   <= '0;
         period_q <= '0;
         err_q    <= '0;
         tick_q   <= 1'b0;
         locked_q <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         good_q   <= good_d;
         period_q <= period_d;
         err_q    <= err_d;
         tick_q   <= tick_d;
         locked_q <= locked_d;
         lost_q   <= lost_d;
      end
   end

   // Next state: interval evaluation, lock tracking and loss-of-clock timeout
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      good_d   = good_q;
      period_d = period_q;
      err_d    = err_q;
      // Ticks follow edges regardless of state, but never while disabled
      tick_d   = edge_w & enable;

      if ((state_q != ST_IDLE) && !cnt_sat) begin
         cnt_d = cnt_q + 1'b1;
      end

      if (!enable) begin
         // period and err_cnt survive a disable; everything else restarts
         state_d = ST_IDLE;
         cnt_d   = '0;
         good_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ACQUIRE;
               cnt_d   = '0;
            end
            ST_ACQUIRE: begin
               // First edge only sets the reference point; no timeout here
               if (edge_w) begin
                  state_d = ST_TRACK;
                  cnt_d   = '0;
                  good_d  = '0;
               end
            end
            ST_TRACK, ST_LOCKED: begin
               // An edge on the threshold cycle wins over the timeout
               if (edge_w) begin
                  cnt_d    = '0;
                  period_d = interval;
                  if (ival_good) begin
                     if (state_q == ST_TRACK) begin
                        good_d = good_inc;
                        if (good_inc >= GOOD_TGT) begin
                           state_d = ST_LOCKED;
                        end
                     end
                  end else begin
                     state_d = ST_TRACK;
                     good_d  = '0;
                     err_d   = err_sat_inc(err_q);
                  end
               end else if (cnt_q == HI_LIM) begin
                  state_d = ST_LOST;
                  good_d  = '0;
                  err_d   = err_sat_inc(err_q);
               end
            end
            ST_LOST: begin
               // Recovery edge restarts measurement but is not evaluated
               if (edge_w) begin
                  state_d = ST_TRACK;
                  cnt_d   = '0;
                  good_d  = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               good_d  = '0;
            end
         endcase
      end
   end

   // Status flags decoded from the next state so they register with the transition
   always_comb begin
      locked_d = (state_d == ST_LOCKED);
      lost_d   = (state_d == ST_LOST);
   end

   assign tick    = tick_q;
   assign period  = period_q;
   assign locked  = locked_q;
   assign lost    = lost_q;
   assign err_cnt = err_q;

endmodule

// File: doc/divclk_tick_receiver.md
Name: divclk_tick_receiver

Overview:
Receiving end of the divided-clock path. It takes a slow divided clock signal, which may be asynchronous to clk, and synchronises it into the clk domain. It converts each detected transition into a single-cycle tick enable and measures the interval between edges. It reports lock and loss-of-clock status to the display/timekeeping logic, so downstream counters run on clk with a clock-enable instead of clocking from the divided signal.

Parameters:
EDGE_MODE, 1, 0 = rising edges of div_in only; 1 = both edges.
EXPECTED_PERIOD, 10000, nominal clk cycles between detected edges.
TOLERANCE, 16, allowed +/- deviation in clk cycles.
LOCK_COUNT, 4, consecutive good intervals required to assert locked (>=1).
CNT_W, 32, interval counter and period width.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
div_in  input  1  divided clock from the divider; treated as asynchronous.
enable  input  1  receiver enable; low forces IDLE.
tick  output  1  single-cycle strobe per detected edge.
period  output  CNT_W  last measured interval in clk cycles.
locked  output  1  interval stable within tolerance.
lost  output  1  no edge within EXPECTED_PERIOD+TOLERANCE cycles.
err_cnt  output  8  saturating count of bad intervals plus timeouts.

Behaviour:
- Reset (clk and reset: reset asynchronous, active-high; clock clk):
  - Sync flops, history flop, cnt and good_cnt cleared to 0.
  - tick, period, locked, lost and err_cnt cleared to 0.
  - State = IDLE.
- Synchroniser and edge detect:
  - 2-flop synchroniser, then a history flop.
  - edge = rise (EDGE_MODE=0) or rise|fall (EDGE_MODE=1) of the synchronised signal.
  - tick is registered and asserts exactly 3 clk cycles after the div_in transition is sampled.
- tick is emitted on every edge whenever enable=1, regardless of state. tick is never asserted while enable=0.
- Interval counter cnt:
  - Increments every cycle when not IDLE.
  - On an edge cycle: interval = cnt+1, then cnt <= 0.
  - Saturates at all-ones and never wraps.
- good interval: EXPECTED_PERIOD-TOLERANCE <= interval <= EXPECTED_PERIOD+TOLERANCE. Any other interval is bad.
- period is updated with the interval on every evaluated edge, good or bad. The first edge after ACQUIRE or LOST is not evaluated.
- FSM states: IDLE, ACQUIRE, TRACK, LOCKED, LOST.
  - IDLE: when enable=1, go to ACQUIRE with cnt=0.
  - ACQUIRE: on first edge go to TRACK with cnt=0 and good_cnt=0. No timeout applies in this state.
  - TRACK:
    - Good interval: good_cnt++; when good_cnt reaches LOCK_COUNT, go to LOCKED.
    - Bad interval: good_cnt=0, err_cnt++.
  - LOCKED: on a bad interval go to TRACK with good_cnt=0 and err_cnt++.
  - Timeout from TRACK or LOCKED: cnt == EXPECTED_PERIOD+TOLERANCE with no edge that cycle → LOST, err_cnt++.
  - LOST: next edge → TRACK with cnt=0. That edge's interval is not evaluated.
- Outputs from state:
  - locked = (state==LOCKED).
  - lost = (state==LOST).
  - Both are registered and update on the clk edge after the state change.
- Simultaneous edge and timeout threshold: the edge wins. Interval = EXPECTED_PERIOD+TOLERANCE+1, which is bad → normal bad-interval handling, no LOST.
- enable deasserted in any state: next cycle go to IDLE and clear cnt, good_cnt, locked and lost. period and err_cnt are retained.
- err_cnt saturates at 255.
- reset asserted mid-operation: all state and outputs clear immediately, asynchronously.

Decomposition:
- Shared package: state encoding (IDLE/ACQUIRE/TRACK/LOCKED/LOST) and edge-mode constants EDGE_RISE and EDGE_BOTH.
- One natural sub-module: sync_edge_detect, containing the 2-flop synchroniser, history flop and EDGE_MODE select, with output edge.
- Interval checker and FSM remain in the top module.

Test Plan:
Default for all scenarios below: EXPECTED_PERIOD=20, TOLERANCE=2, LOCK_COUNT=4, EDGE_MODE=1.
1. Assert reset mid-run → tick, period, locked, lost and err_cnt = 0 in the same cycle; IDLE after release with enable=0.
2. enable=1, div_in toggling every 20 cycles → tick 3 cycles after each toggle; period=20; locked rises after the 5th tick; err_cnt=0.
3. While locked, one half-period of 24 cycles → period=24, locked drops, err_cnt=1; relocks after 4 further 20-cycle intervals.
4. Stop toggling while locked → lost=1 exactly 23 cycles after the last tick, err_cnt+1. The next toggle → TRACK (lost=0); the following interval is evaluated normally.
5. Edge arriving exactly when cnt==22 → no LOST, period=23, err_cnt+1.
6. EDGE_MODE=0, EXPECTED_PERIOD=40, toggling every 20 cycles → tick only on rising edges and period=40. Deassert enable while locked → locked=0 next cycle, period holds 40, no ticks.
